// File: rtl/pulse_width_adc_if.sv
// soc/eoc converter handshake bundle: soc from the consumer, eoc and x back.
// Combinational wiring only, no latency.
// The consumer holds soc until eoc falls, then waits for eoc to rise before using x.
interface pulse_width_adc_if #(
  parameter int WIDTH = 8
);
  logic             soc;
  logic             eoc;
  logic [WIDTH-1:0] x;

  // Consumer side: starts conversions and reads results
  modport master (output soc, input eoc, input x);
  // Converter side: answers soc with eoc and x
  modport slave  (input soc, output eoc, output x);
endinterface

// File: rtl/pulse_width_adc.sv
// Measures high-pulse widths on pulse_in, queues them, serves them over soc/eoc.
// Latency: entry poppable one edge after the falling edge; eoc falls CONV_CYCLES after soc, rises DATA_CYCLES after soc low.
// Backpressure: full FIFO drops new widths (sticky overflow); empty FIFO stalls the conversion in LOAD.
module pulse_width_adc #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int CONV_CYCLES = 2,
  parameter int DATA_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pulse_in,
  output logic               overflow,
  pulse_width_adc_if.slave   bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int DMAX = (CONV_CYCLES > DATA_CYCLES) ? CONV_CYCLES : DATA_CYCLES;
  localparam int DW   = (DMAX < 2) ? 1 : $clog2(DMAX);

  typedef enum logic [1:0] {IDLE, CONV, BUSY, LOAD} state_t;

  // Pulse measurement
  logic             pin_q;
  logic             meas_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             rise, push;

  // FIFO storage; pointers carry one extra wrap bit to tell full from empty
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             empty, full, pop;

  // Converter FSM
  state_t           state_q;
  logic [DW-1:0]    dly_q;
  logic             eoc_q;
  logic [WIDTH-1:0] x_q;
  logic             ovf_q;

  assign rise  = ~pin_q & pulse_in;
  // meas_q gates the push so a pulse already high at reset release is never queued
  assign push  = pin_q & ~pulse_in & meas_q;
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = (state_q == LOAD) && (dly_q == '0) && !empty;

  assign bus.eoc  = eoc_q;
  assign bus.x    = x_q;
  assign overflow = ovf_q;

  // Width counter next state: load 1 on rising edge, saturate while high
  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = WIDTH'(1);
    end else if (pin_q && pulse_in && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Input history, measurement-in-progress flag and width counter
  always_ff @(posedge clock) begin
    if (reset) begin
      pin_q  <= 1'b1;
      meas_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pin_q <= pulse_in;
      cnt_q <= cnt_d;
      if (rise) begin
        meas_q <= 1'b1;
      end else if (push) begin
        meas_q <= 1'b0;
      end
    end
  end

  // FIFO data array; contents are only meaningful between the pointers
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem_q[wr_q[AW-1:0]] <= cnt_q;
    end
  end

  // FIFO pointers and sticky overflow; pop sees only pre-edge occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) begin
        if (full) begin
          ovf_q <= 1'b1;
        end else begin
          wr_q <= wr_q + 1'b1;
        end
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

  // Converter handshake FSM with registered eoc and x
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      dly_q   <= '0;
      eoc_q   <= 1'b1;
      x_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.soc) begin
            state_q <= CONV;
            dly_q   <= DW'(CONV_CYCLES - 1);
          end
        end
        CONV: begin
          if (dly_q == '0) begin
            eoc_q   <= 1'b0;
            state_q <= BUSY;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        BUSY: begin
          if (!bus.soc) begin
            state_q <= LOAD;
            dly_q   <= DW'(DATA_CYCLES - 1);
          end
        end
        LOAD: begin
          if (dly_q != '0) begin
            dly_q <= dly_q - 1'b1;
          end else if (!empty) begin
            x_q     <= mem_q[rd_q[AW-1:0]];
            eoc_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
